// File: rtl/memory_interface_if.sv
// Bus bundle for memory_interface: processor-side request/ack handshake
// plus the memory-side address/data/select/strobe bus.
interface memory_interface_if;
  // Processor side
  logic        req;
  logic        wr;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        bus_err;
  // Memory side
  logic [15:0] mem_a;
  logic [7:0]  mem_d_out;
  logic        mem_d_oe;
  logic [7:0]  mem_d_in;
  logic        eprom_s_;
  logic        ram_s_;
  logic        mr_;
  logic        mw_;

  // The controller itself
  modport slave (
    input  req, wr, addr, wdata, mem_d_in,
    output ack, rdata, bus_err, mem_a, mem_d_out, mem_d_oe,
           eprom_s_, ram_s_, mr_, mw_
  );

  // Whoever surrounds the controller: the processor and the memory devices
  modport master (
    output req, wr, addr, wdata, mem_d_in,
    input  ack, rdata, bus_err, mem_a, mem_d_out, mem_d_oe,
           eprom_s_, ram_s_, mr_, mw_
  );
endinterface

// File: rtl/memory_interface.sv
// Processor-to-memory bridge: decodes a 24-bit address into a 64K RAM window
// (000000-00FFFF) and a 64K EPROM window (FF0000-FFFFFF), sequences
// select/strobe timing with per-region wait states, and completes each
// access with a 4-phase req/ack handshake. Unmapped accesses and EPROM
// writes terminate immediately with bus_err and rdata=FF.
module memory_interface #(
  parameter int EPROM_WAIT = 2,
  parameter int RAM_WAIT   = 1
) (
  input logic           clock,
  input logic           reset_,
  memory_interface_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  localparam logic [3:0] EPROM_WAIT_C = 4'(EPROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C   = 4'(RAM_WAIT);

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        eprom_q, eprom_d;   // latched region: 1 = EPROM, 0 = RAM
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;

  logic hit_ram, hit_eprom, in_cycle;

  assign hit_ram   = (bus.addr[23:16] == 8'h00);
  assign hit_eprom = (bus.addr[23:16] == 8'hFF);

  // Next-state logic: sequence IDLE -> SETUP -> ACCESS (WAIT+1) -> HOLD -> ACK
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    eprom_d = eprom_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (!(hit_ram || hit_eprom) || (hit_eprom && bus.wr)) begin
            // Failed access: no memory cycle, complete straight away.
            state_d = S_ACK;
            err_d   = 1'b1;
            rdata_d = 8'hFF;
          end else begin
            state_d = S_SETUP;
            addr_d  = bus.addr[15:0];
            wr_d    = bus.wr;
            wdata_d = bus.wdata;
            eprom_d = hit_eprom;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = eprom_q ? EPROM_WAIT_C : RAM_WAIT_C;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          if (!wr_q) begin
            rdata_d = bus.mem_d_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!bus.req) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared by reset_
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      eprom_q <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      eprom_q <= eprom_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from state so reset deasserts every select and strobe
  // at once; exactly one select can be active because eprom_q picks it.
  assign in_cycle      = (state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_HOLD);
  assign bus.eprom_s_  = ~(in_cycle && eprom_q);
  assign bus.ram_s_    = ~(in_cycle && !eprom_q);
  assign bus.mr_       = ~((state_q == S_ACCESS) && !wr_q);
  assign bus.mw_       = ~((state_q == S_ACCESS) && wr_q);
  assign bus.mem_d_oe  = in_cycle && wr_q;
  assign bus.mem_d_out = wdata_q;
  assign bus.mem_a     = addr_q;
  assign bus.ack       = (state_q == S_ACK);
  assign bus.rdata     = rdata_q;
  assign bus.bus_err   = err_q;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: byte-wide RAM/EPROM device models on the
// memory bus, a directed vector table, hand-written corner sequences and
// randomized accesses checked against an address-map reference model.
module tb_memory_interface;

  logic clock;
  logic reset_;

  memory_interface_if bus ();
  memory_interface_if bus2 ();

  memory_interface #(.EPROM_WAIT(2), .RAM_WAIT(1)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  memory_interface #(.EPROM_WAIT(2), .RAM_WAIT(0)) dut2 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Device contents at power-up
  function automatic logic [7:0] ram_init(input logic [15:0] a);
    if (a == 16'h0020) return 8'h42;
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] eprom_init(input logic [15:0] a);
    if (a == 16'h0000) return 8'hA5;
    if (a == 16'h0001) return 8'h5A;
    return a[7:0] ^ 8'hC3;
  endfunction

  // Device models (shared by both controllers; dut2 only reads)
  logic [7:0] ram_mem   [0:65535];
  logic [7:0] eprom_mem [0:65535];

  assign bus.mem_d_in  = !bus.eprom_s_  ? eprom_mem[bus.mem_a]  :
                         !bus.ram_s_    ? ram_mem[bus.mem_a]    : 8'h00;
  assign bus2.mem_d_in = !bus2.eprom_s_ ? eprom_mem[bus2.mem_a] :
                         !bus2.ram_s_   ? ram_mem[bus2.mem_a]   : 8'h00;

  // RAM commits on the rising edge of mw_ while still selected
  initial begin
    logic mw_prev;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i]   = ram_init(16'(i));
      eprom_mem[i] = eprom_init(16'(i));
    end
    mw_prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mw_prev === 1'b0 && bus.mw_ === 1'b1 && bus.ram_s_ === 1'b0)
        ram_mem[bus.mem_a] = bus.mem_d_out;
      mw_prev = bus.mw_;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else
      pass_cnt++;
  endtask

  // Reference model state
  logic [7:0] ref_ram [0:65535];
  logic [7:0] model_rdata;

  // One processor transaction on dut. lat = number of clock edges after the
  // request edge before ack is visible; nstrobe = cycles with a strobe low;
  // nviol = protocol violations seen anywhere in the transaction.
  task automatic do_access(input logic w, input logic [23:0] a, input logic [7:0] d,
                           input int hold, output int lat, output logic [7:0] rd,
                           output logic e, output int nstrobe, output int nviol);
    @(negedge clock);
    bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    @(posedge clock);
    #1;
    // Request is latched; later bus changes must not matter.
    bus.wr = ~w; bus.addr = 24'($urandom); bus.wdata = 8'($urandom);
    lat = 0; nstrobe = 0; nviol = 0;
    while (1) begin
      @(negedge clock);
      if (!bus.eprom_s_ && !bus.ram_s_) nviol++;
      if (!bus.mr_ && !bus.mw_) nviol++;
      if (!bus.mr_ || !bus.mw_) nstrobe++;
      if (w && !bus.mr_) nviol++;
      if (!w && !bus.mw_) nviol++;
      if (w && !bus.mw_ && (!bus.mem_d_oe || bus.mem_d_out !== d)) nviol++;
      if (!w && bus.mem_d_oe) nviol++;
      if (bus.ack) begin
        if (!bus.eprom_s_ || !bus.ram_s_ || !bus.mr_ || !bus.mw_) nviol++;
        break;
      end
      if (lat == 40) begin
        nviol += 100;
        break;
      end
      @(posedge clock);
      lat++;
    end
    rd = bus.rdata;
    e  = bus.bus_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!bus.ack || !bus.eprom_s_ || !bus.ram_s_ || !bus.mr_ || !bus.mw_) nviol++;
    end
    bus.req = 1'b0;
    @(negedge clock);
    if (bus.ack || bus.bus_err) nviol++;
  endtask

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [7:0]  d;
    int          hold;
    logic [7:0]  exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_strobe;
  } vec_t;

  vec_t vecs [11];

  // Reference model: expected result of an access from the address map
  task automatic model(input logic w, input logic [23:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic e, output int lat, output int st);
    logic is_ram, is_ep;
    int wt;
    is_ram = (a[23:16] == 8'h00);
    is_ep  = (a[23:16] == 8'hFF);
    e = !(is_ram || (is_ep && !w));
    wt = is_ep ? 2 : 1;
    if (e) begin
      rd = 8'hFF; lat = 0; st = 0;
    end else begin
      lat = 3 + wt; st = wt + 1;
      if (w) begin
        rd = model_rdata;
        ref_ram[a[15:0]] = d;
      end else begin
        rd = is_ep ? eprom_init(a[15:0]) : ref_ram[a[15:0]];
      end
    end
    model_rdata = rd;
  endtask

  initial begin
    int lat, nst, nviol, acks, first, strobes;
    logic [7:0] rd;
    logic e;
    logic [7:0] mrd;
    logic me;
    int mlat, mst;
    string nm;

    for (int i = 0; i < 65536; i++) ref_ram[i] = ram_init(16'(i));
    model_rdata = 8'h00;

    vecs[0]  = '{1'b0, 24'hFF0000, 8'h00, 5, 8'hA5, 1'b0, 5, 3};
    vecs[1]  = '{1'b1, 24'h000010, 8'h3C, 0, 8'hA5, 1'b0, 4, 2};
    vecs[2]  = '{1'b0, 24'h000010, 8'h00, 0, 8'h3C, 1'b0, 4, 2};
    vecs[3]  = '{1'b0, 24'h800000, 8'h00, 1, 8'hFF, 1'b1, 0, 0};
    vecs[4]  = '{1'b1, 24'hFF0001, 8'h77, 0, 8'hFF, 1'b1, 0, 0};
    vecs[5]  = '{1'b0, 24'hFF0001, 8'h00, 0, 8'h5A, 1'b0, 5, 3};
    vecs[6]  = '{1'b0, 24'h010000, 8'h00, 0, 8'hFF, 1'b1, 0, 0};
    vecs[7]  = '{1'b0, 24'hFEFFFF, 8'h00, 0, 8'hFF, 1'b1, 0, 0};
    vecs[8]  = '{1'b1, 24'h00FFFF, 8'h99, 2, 8'hFF, 1'b0, 4, 2};
    vecs[9]  = '{1'b0, 24'h00FFFF, 8'h00, 0, 8'h99, 1'b0, 4, 2};
    vecs[10] = '{1'b0, 24'hFFFFFF, 8'h00, 0, 8'h3C, 1'b0, 5, 3};

    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 24'h0; bus.wdata = 8'h0;
    bus2.req = 1'b0; bus2.wr = 1'b0; bus2.addr = 24'h0; bus2.wdata = 8'h0;
    reset_ = 1'b0;

    // Reset state
    #12;
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.bus_err, 0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_sel_strb", {bus.eprom_s_, bus.ram_s_, bus.mr_, bus.mw_}, 4'hF);
    chk("rst_mem_a", bus.mem_a, 16'h0000);
    chk("rst_dout_oe", {bus.mem_d_out, bus.mem_d_oe}, 9'h000);
    @(negedge clock);
    reset_ = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold, lat, rd, e, nst, nviol);
      $display("vec %0d: wr=%0d addr=%06h wdata=%02h -> rdata=%02h err=%0d lat=%0d strobes=%0d",
               i, vecs[i].w, vecs[i].a, vecs[i].d, rd, e, lat, nst);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_rdata"}, rd, vecs[i].exp_rd);
      chk({nm, "_err"}, e, vecs[i].exp_err);
      chk({nm, "_lat"}, lat, vecs[i].exp_lat);
      chk({nm, "_strobes"}, nst, vecs[i].exp_strobe);
      chk({nm, "_protocol"}, nviol, 0);
      if (vecs[i].w && vecs[i].a[23:16] == 8'h00 && !vecs[i].exp_err)
        ref_ram[vecs[i].a[15:0]] = vecs[i].d;
      model_rdata = vecs[i].exp_rd;
    end
    chk("eprom_unchanged", eprom_mem[1], 8'h5A);
    chk("ram_written", ram_mem[16'h0010], 8'h3C);

    // req dropped before ack: access still completes, ack for one cycle
    @(negedge clock);
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 24'h000030;
    @(posedge clock);
    #1 bus.req = 1'b0;
    acks = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.ack) begin
        acks++;
        if (first < 0) first = i;
      end
      @(posedge clock);
    end
    @(negedge clock);
    $display("early drop: acks=%0d first=%0d rdata=%02h", acks, first, bus.rdata);
    chk("early_drop_acks", acks, 1);
    chk("early_drop_lat", first, 4);
    chk("early_drop_rdata", bus.rdata, ref_ram[16'h0030]);
    model_rdata = ref_ram[16'h0030];

    // Reset during the write strobe of a RAM write
    @(negedge clock);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 24'h000020; bus.wdata = 8'hEE;
    @(posedge clock);
    lat = 0;
    while (bus.mw_ !== 1'b0 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("rst_mid_reached_strobe", bus.mw_, 0);
    #1 reset_ = 1'b0;
    #1;
    chk("rst_mid_sel_strb", {bus.eprom_s_, bus.ram_s_, bus.mr_, bus.mw_}, 4'hF);
    chk("rst_mid_ack_oe", {bus.ack, bus.mem_d_oe}, 2'b00);
    bus.req = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.ack) acks++;
    end
    $display("reset mid-access: acks=%0d ram[0020]=%02h", acks, ram_mem[16'h0020]);
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_ram_kept", ram_mem[16'h0020], 8'h42);
    model_rdata = 8'h00;
    do_access(1'b0, 24'h000020, 8'h00, 0, lat, rd, e, nst, nviol);
    $display("post-reset read 000020 -> rdata=%02h err=%0d lat=%0d", rd, e, lat);
    chk("post_rst_rdata", rd, 8'h42);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_protocol", nviol, 0);
    model_rdata = 8'h42;

    // Zero-wait RAM read on the second controller
    @(negedge clock);
    bus2.req = 1'b1; bus2.wr = 1'b0; bus2.addr = 24'h000040;
    @(posedge clock);
    lat = 0; strobes = 0;
    while (1) begin
      @(negedge clock);
      if (!bus2.mr_) strobes++;
      if (bus2.ack || lat == 20) break;
      @(posedge clock);
      lat++;
    end
    rd = bus2.rdata;
    bus2.req = 1'b0;
    @(negedge clock);
    $display("wait0 read 000040 -> rdata=%02h lat=%0d strobes=%0d", rd, lat, strobes);
    chk("wait0_lat", lat, 3);
    chk("wait0_strobes", strobes, 1);
    chk("wait0_rdata", rd, ref_ram[16'h0040]);
    chk("wait0_ack_clear", bus2.ack, 0);

    // Randomized accesses against the reference model
    for (int i = 0; i < 150; i++) begin
      logic w;
      logic [23:0] a;
      logic [7:0] d;
      int r;
      w = 1'($urandom);
      d = 8'($urandom);
      r = $urandom_range(0, 2);
      if (r == 0)      a = {8'h00, 16'($urandom)};
      else if (r == 1) a = {8'hFF, 16'($urandom)};
      else             a = {8'($urandom_range(1, 254)), 16'($urandom)};
      model(w, a, d, mrd, me, mlat, mst);
      do_access(w, a, d, $urandom_range(0, 2), lat, rd, e, nst, nviol);
      $display("rand %0d: wr=%0d addr=%06h wdata=%02h -> rdata=%02h err=%0d lat=%0d strobes=%0d",
               i, w, a, d, rd, e, lat, nst);
      chk("rand_rdata", rd, mrd);
      chk("rand_err", e, me);
      chk("rand_lat", lat, mlat);
      chk("rand_strobes", nst, mst);
      chk("rand_protocol", nviol, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
